// File: rtl/scoreboard_if.sv
// Bundle between ProcessControl/display (master) and the high-score table
// controller (slave).
interface scoreboard_if #(
    parameter int SCORE_W = 32,
    parameter int ID_W    = 16
);
    // Handshake: submit/clear_req are sampled only on a clock edge where busy=0,
    // and anything asserted while busy=1 is dropped, not queued. done is a
    // one-cycle pulse that qualifies qualified/rank. rd_* lag rd_index by one
    // cycle and are meaningful only while busy=0.
    logic               submit;
    logic [SCORE_W-1:0] submit_score;
    logic [ID_W-1:0]    submit_userid;
    logic               clear_req;
    logic               busy;
    logic               done;
    logic               qualified;
    logic [2:0]         rank;
    logic [3:0]         entry_count;
    logic [2:0]         rd_index;
    logic [SCORE_W-1:0] rd_score;
    logic [ID_W-1:0]    rd_userid;
    logic               rd_valid;

    modport master (
        output submit, submit_score, submit_userid, clear_req, rd_index,
        input  busy, done, qualified, rank, entry_count, rd_score, rd_userid, rd_valid
    );

    modport slave (
        input  submit, submit_score, submit_userid, clear_req, rd_index,
        output busy, done, qualified, rank, entry_count, rd_score, rd_userid, rd_valid
    );
endinterface

// File: rtl/scoreboard_controller.sv
// High-score table: sorted insert by sequential insertion sort (one entry
// moved per cycle), whole-table clear, and a registered read port.
module scoreboard_controller #(
    parameter int DEPTH   = 4,
    parameter int SCORE_W = 32,
    parameter int ID_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    scoreboard_if.slave bus,
    output logic [2:0]  o_dbg_state
);
    localparam int         IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] LAST  = 3'(DEPTH - 1);
    localparam logic [3:0] FULL  = 4'(DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_SCAN  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]         r_state;
    logic [DEPTH-1:0]   r_valid;
    logic [SCORE_W-1:0] r_score  [DEPTH];
    logic [ID_W-1:0]    r_userid [DEPTH];
    logic [SCORE_W-1:0] r_new_score;
    logic [ID_W-1:0]    r_new_userid;
    logic [2:0]         r_k;
    logic [2:0]         r_pos;
    logic [2:0]         r_j;
    logic               r_ins_ok;
    logic               r_done;
    logic               r_qualified;
    logic [2:0]         r_rank;
    logic [3:0]         r_count;
    logic [SCORE_W-1:0] r_rd_score;
    logic [ID_W-1:0]    r_rd_userid;
    logic               r_rd_valid;

    logic [2:0]       w_jm1;
    logic [IDX_W-1:0] w_k_idx;
    logic [IDX_W-1:0] w_j_idx;
    logic [IDX_W-1:0] w_jm1_idx;
    logic [IDX_W-1:0] w_pos_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_hit;

    assign w_jm1     = r_j - 3'd1;
    assign w_k_idx   = r_k[IDX_W-1:0];
    assign w_j_idx   = r_j[IDX_W-1:0];
    assign w_jm1_idx = w_jm1[IDX_W-1:0];
    assign w_pos_idx = r_pos[IDX_W-1:0];
    assign w_rd_idx  = bus.rd_index[IDX_W-1:0];
    // Strict compare: an equal score lands below the older entry.
    assign w_hit     = !r_valid[w_k_idx] || (r_new_score > r_score[w_k_idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_valid      <= '0;
            r_new_score  <= '0;
            r_new_userid <= '0;
            r_k          <= '0;
            r_pos        <= '0;
            r_j          <= '0;
            r_ins_ok     <= 1'b0;
            r_done       <= 1'b0;
            r_qualified  <= 1'b0;
            r_rank       <= '0;
            r_count      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_score[i]  <= '0;
                r_userid[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.clear_req) begin
                        r_state <= ST_CLEAR;
                    end else if (bus.submit) begin
                        r_new_score  <= bus.submit_score;
                        r_new_userid <= bus.submit_userid;
                        r_k          <= '0;
                        r_ins_ok     <= 1'b0;
                        r_state      <= ST_SCAN;
                    end
                end
                ST_CLEAR: begin
                    r_valid <= '0;
                    r_count <= '0;
                    r_state <= ST_IDLE;
                end
                ST_SCAN: begin
                    if (w_hit) begin
                        r_pos   <= r_k;
                        r_j     <= LAST;
                        r_state <= (r_k == LAST) ? ST_WRITE : ST_SHIFT;
                    end else if (r_k == LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                ST_SHIFT: begin
                    // Bottom-up move; the old last entry falls off when full.
                    r_valid[w_j_idx]  <= r_valid[w_jm1_idx];
                    r_score[w_j_idx]  <= r_score[w_jm1_idx];
                    r_userid[w_j_idx] <= r_userid[w_jm1_idx];
                    r_j               <= w_jm1;
                    if (r_j == r_pos + 3'd1) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_valid[w_pos_idx]  <= 1'b1;
                    r_score[w_pos_idx]  <= r_new_score;
                    r_userid[w_pos_idx] <= r_new_userid;
                    r_count             <= (r_count == FULL) ? FULL : r_count + 4'd1;
                    r_ins_ok            <= 1'b1;
                    r_state             <= ST_DONE;
                end
                ST_DONE: begin
                    r_done      <= 1'b1;
                    r_qualified <= r_ins_ok;
                    r_rank      <= r_ins_ok ? r_pos : 3'd0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid  <= 1'b0;
            r_rd_score  <= '0;
            r_rd_userid <= '0;
        end else if ({1'b0, bus.rd_index} < FULL) begin
            r_rd_valid  <= r_valid[w_rd_idx];
            r_rd_score  <= r_score[w_rd_idx];
            r_rd_userid <= r_userid[w_rd_idx];
        end else begin
            r_rd_valid  <= 1'b0;
            r_rd_score  <= '0;
            r_rd_userid <= '0;
        end
    end

    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = r_done;
    assign bus.qualified   = r_qualified;
    assign bus.rank        = r_rank;
    assign bus.entry_count = r_count;
    assign bus.rd_score    = r_rd_score;
    assign bus.rd_userid   = r_rd_userid;
    assign bus.rd_valid    = r_rd_valid;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_scoreboard_controller.sv
// Randomized bench for scoreboard_controller against a sorted-queue model of
// the high-score table.
module tb_scoreboard_controller;
    localparam int DEPTH   = 4;
    localparam int SCORE_W = 32;
    localparam int ID_W    = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;

    scoreboard_if #(.SCORE_W(SCORE_W), .ID_W(ID_W)) bus ();

    scoreboard_controller #(.DEPTH(DEPTH), .SCORE_W(SCORE_W), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    logic [SCORE_W-1:0] m_score[$];
    logic [ID_W-1:0]    m_id[$];
    logic [3:0]         exp_q[$];
    int                 seq_scores[4] = '{50, 200, 150, 10};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the rank the new entry takes, or DEPTH when it does not qualify.
    function automatic int model_insert(input logic [SCORE_W-1:0] score, input logic [ID_W-1:0] id);
        int pos;
        pos = m_score.size();
        for (int i = 0; i < m_score.size(); i++) begin
            if (score > m_score[i]) begin
                pos = i;
                break;
            end
        end
        if (pos >= DEPTH) return DEPTH;
        m_score.insert(pos, score);
        m_id.insert(pos, id);
        if (m_score.size() > DEPTH) begin
            void'(m_score.pop_back());
            void'(m_id.pop_back());
        end
        return pos;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst               = 1'b1;
        bus.submit        = 1'b0;
        bus.clear_req     = 1'b0;
        bus.submit_score  = '0;
        bus.submit_userid = '0;
        bus.rd_index      = '0;
        step();
        step();
        rst = 1'b0;
        m_score.delete();
        m_id.delete();
        exp_q.delete();
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i <= DEPTH && i < 8; i++) begin
            bus.rd_index = 3'(i);
            step();
            if (i < m_score.size()) begin
                check($sformatf("%s_valid%0d", tag, i), 64'(bus.rd_valid), 64'd1);
                check($sformatf("%s_score%0d", tag, i), 64'(bus.rd_score), 64'(m_score[i]));
                check($sformatf("%s_id%0d", tag, i), 64'(bus.rd_userid), 64'(m_id[i]));
            end else if (i < DEPTH) begin
                check($sformatf("%s_valid%0d", tag, i), 64'(bus.rd_valid), 64'd0);
            end else begin
                check($sformatf("%s_oob", tag), {bus.rd_valid, 15'd0, bus.rd_userid, bus.rd_score}, 64'd0);
            end
        end
        check($sformatf("%s_count", tag), 64'(bus.entry_count), 64'(m_score.size()));
    endtask

    task automatic do_clear();
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        check("clear_busy", 64'(bus.busy), 64'd1);
        step();
        check("clear_idle", 64'(bus.busy), 64'd0);
        m_score.delete();
        m_id.delete();
    endtask

    task automatic do_insert(input logic [SCORE_W-1:0] score, input logic [ID_W-1:0] id, input bit poke);
        int   pos;
        int   n;
        int   extra;
        bit   seen;
        logic [3:0] exp;
        pos = model_insert(score, id);
        exp_q.push_back(pos < DEPTH ? {1'b1, 3'(pos)} : 4'b0000);
        bus.submit        = 1'b1;
        bus.submit_score  = score;
        bus.submit_userid = id;
        step();
        bus.submit = 1'b0;
        check("accept_busy", 64'(bus.busy), 64'd1);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 40) begin
            if (poke && n == 1) begin
                bus.submit        = 1'b1;
                bus.clear_req     = 1'b1;
                bus.submit_score  = '1;
                bus.submit_userid = 16'hDEAD;
            end else begin
                bus.submit    = 1'b0;
                bus.clear_req = 1'b0;
            end
            step();
            n++;
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(n), (pos < DEPTH) ? 64'(DEPTH + 2) : 64'(DEPTH + 1));
        exp = exp_q.pop_front();
        check("result", {60'd0, bus.qualified, bus.rank}, 64'(exp));
        check("count", 64'(bus.entry_count), 64'(m_score.size()));
        check("busy_at_done", 64'(bus.busy), 64'd0);
        extra = 0;
        for (int c = 0; c < (poke ? 12 : 1); c++) begin
            step();
            if (bus.done) extra++;
        end
        check("single_done", 64'(extra), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   nd;
        logic [SCORE_W-1:0] s;
        logic [ID_W-1:0]    u;

        do_reset();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_qual_rank", {60'd0, bus.qualified, bus.rank}, 64'd0);
        check("rst_count", 64'(bus.entry_count), 64'd0);
        check("rst_rd", {bus.rd_valid, 15'd0, bus.rd_userid, bus.rd_score}, 64'd0);

        do_insert(32'd100, 16'h00A1, 1'b0);
        check_table("t1");

        for (int i = 0; i < 4; i++) begin
            do_insert(32'(seq_scores[i]), 16'(16'h0B00 + i), 1'b0);
        end
        check_table("t2");

        do_insert(32'd50, 16'h0C50, 1'b0);
        do_insert(32'd120, 16'h0C12, 1'b0);
        check_table("t3");

        // Clear and submit together: clear wins, submit dropped.
        bus.clear_req    = 1'b1;
        bus.submit       = 1'b1;
        bus.submit_score = 32'd999;
        step();
        bus.clear_req = 1'b0;
        bus.submit    = 1'b0;
        check("clr_sub_busy", 64'(bus.busy), 64'd1);
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) check("clr_sub_idle", 64'(bus.busy), 64'd0);
            if (bus.done) nd++;
        end
        check("clr_sub_nodone", 64'(nd), 64'd0);
        m_score.delete();
        m_id.delete();
        check_table("t4");

        do_insert(32'd77, 16'h0077, 1'b1);
        check_table("t5");

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 11) == 0) begin
                do_clear();
            end else begin
                s = 32'($urandom_range(0, 60));
                u = 16'($urandom_range(0, 65535));
                do_insert(s, u, $urandom_range(0, 4) == 0);
            end
            check_table($sformatf("r%0d", it));
        end

        // Reset while SHIFT is moving entries.
        do_clear();
        do_insert(32'd10, 16'h0010, 1'b0);
        do_insert(32'd20, 16'h0020, 1'b0);
        do_insert(32'd30, 16'h0030, 1'b0);
        bus.submit        = 1'b1;
        bus.submit_score  = 32'd500;
        bus.submit_userid = 16'h0500;
        step();
        bus.submit = 1'b0;
        step();
        step();
        check("mid_shift_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_shift_busy", 64'(bus.busy), 64'd0);
        check("rst_shift_done", 64'(bus.done), 64'd0);
        check("rst_shift_count", 64'(bus.entry_count), 64'd0);
        m_score.delete();
        m_id.delete();
        exp_q.delete();
        check_table("t6");
        do_insert(32'd7, 16'h0007, 1'b0);
        check("rank_after_rst", 64'(bus.rank), 64'd0);
        check_table("t7");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
